mgr_array_sync_cntl: RTL and testbench

Parametrised barrier/synchronisation controller for the manager array. It replaces the fixed per-manager `allSynchronized`/`thisSynchronized`/`ready`/`complete` tie-offs with a configurable engine with these features:
- participation mask covering any subset of `NUM_MGR` managers;
- a programmable run of 1..2^CNT_W−1 barriers, or unbounded;
- a timeout with a missing-manager report.

It sits beside the manager generate loop in the array top and drives the `sys__mgr__*` general-control inputs of every manager.

---
 rtl/mgr_array_sync_cntl_pkg.sv | 18 +
 rtl/mgr_array_sync_cntl_arrival_tracker.sv | 48 ++++
 rtl/mgr_array_sync_cntl.sv | 172 +++++++++++++++++
 tb/tb_mgr_array_sync_cntl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mgr_array_sync_cntl_pkg.sv
// Shared definitions for the manager-array barrier controller: default
// sizes and the controller state encoding.
package mgr_array_sync_cntl_pkg;

    localparam int MGR_SYNC_DEFAULT_NUM_MGR     = 64;
    localparam int MGR_SYNC_DEFAULT_CNT_W       = 16;
    localparam int MGR_SYNC_DEFAULT_TIMEOUT_W   = 20;
    localparam int MGR_SYNC_DEFAULT_INIT_CYCLES = 16;

    typedef enum logic [2:0] {
        SYNC_INIT    = 3'd0,
        SYNC_IDLE    = 3'd1,
        SYNC_ARMED   = 3'd2,
        SYNC_RELEASE = 3'd3,
        SYNC_TIMEOUT = 3'd4
    } sync_state_e;

endpackage

// File: rtl/mgr_array_sync_cntl_arrival_tracker.sv
// Per-manager arrival tracking: edge detection on the managers' barrier
// levels, the sticky arrived vector and the all-arrived reduction.
// A level that is already high when tracking starts is not an arrival;
// the manager has to drop and re-raise it.
module mgr_sync_arrival_tracker #(
    parameter int NUM_MGR = 64
) (
    input  logic               clk,
    input  logic               reset_poweron,
    input  logic [NUM_MGR-1:0] level,
    input  logic [NUM_MGR-1:0] mask,
    input  logic               track,
    input  logic               clear,
    output logic [NUM_MGR-1:0] hit,
    output logic               all_arrived
);

    logic [NUM_MGR-1:0] level_q;
    logic [NUM_MGR-1:0] arrived;
    logic [NUM_MGR-1:0] rise;

    // Rising edges only count while tracking and only for masked managers.
    assign rise        = level & ~level_q & mask & {NUM_MGR{track}};
    assign hit         = (arrived | rise) & mask;
    assign all_arrived = track && (hit == mask);

    // Previous level is followed in every state so entry into tracking never
    // sees a stale low value.
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            level_q <= '0;
        end else begin
            level_q <= level;
        end
    end

    // Sticky arrivals: clear wins, track accumulates, otherwise frozen.
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            arrived <= '0;
        end else if (clear) begin
            arrived <= '0;
        end else if (track) begin
            arrived <= hit;
        end
    end

endmodule

// File: rtl/mgr_array_sync_cntl.sv
// Barrier/synchronisation controller for the manager array. Runs a power-on
// init delay, then accepts a configuration (mask, barrier count, per-barrier
// timeout) and releases the participating managers each time all of them
// have raised their barrier level.
//
// Config handshake: a configuration is taken on a clock edge where
// cfg__sync__valid and cfg__sync__ready are both high and the mask is
// non-zero; a zero mask is dropped without a state change. Ready is high
// in IDLE and in TIMEOUT (a stuck barrier may be replaced by a new config).
//
// missing reports mask & ~arrived while a barrier is open (ARMED), is frozen
// in TIMEOUT, and reads zero otherwise.
module mgr_array_sync_cntl
    import mgr_array_sync_cntl_pkg::*;
#(
    parameter int NUM_MGR     = MGR_SYNC_DEFAULT_NUM_MGR,
    parameter int CNT_W       = MGR_SYNC_DEFAULT_CNT_W,
    parameter int TIMEOUT_W   = MGR_SYNC_DEFAULT_TIMEOUT_W,
    parameter int INIT_CYCLES = MGR_SYNC_DEFAULT_INIT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset_poweron,
    input  logic                 cfg__sync__valid,
    output logic                 cfg__sync__ready,
    input  logic [NUM_MGR-1:0]   cfg__sync__mask,
    input  logic [CNT_W-1:0]     cfg__sync__numBarriers,
    input  logic [TIMEOUT_W-1:0] cfg__sync__timeout,
    input  logic                 cfg__sync__abort,
    input  logic [NUM_MGR-1:0]   mgr__sys__allSynchronized,
    output logic [NUM_MGR-1:0]   sys__mgr__thisSynchronized,
    output logic [NUM_MGR-1:0]   sys__mgr__ready,
    output logic [NUM_MGR-1:0]   sys__mgr__complete,
    output logic [CNT_W-1:0]     sys__sync__barrierCount,
    output logic [NUM_MGR-1:0]   sys__sync__missing,
    output logic                 sys__sync__timeoutErr,
    output sync_state_e          sys__sync__state
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    sync_state_e          state;
    logic [INIT_W-1:0]    init_cnt;
    logic [NUM_MGR-1:0]   mask_q;
    logic [CNT_W-1:0]     num_q;
    logic [TIMEOUT_W-1:0] limit_q;
    logic [TIMEOUT_W-1:0] tcnt;

    logic                 cfg_take;
    logic                 abort_ok;
    logic [CNT_W-1:0]     count_inc;
    logic                 last_barrier;
    logic                 expire;
    logic                 track;
    logic                 clear;
    logic [NUM_MGR-1:0]   hit;
    logic                 all_arrived;

    assign cfg_take     = cfg__sync__valid && cfg__sync__ready && (|cfg__sync__mask);
    assign abort_ok     = cfg__sync__abort && !all_arrived;
    assign count_inc    = sys__sync__barrierCount + CNT_W'(1);
    assign last_barrier = (num_q != '0) && (count_inc == num_q);
    assign expire       = (limit_q != '0) && (tcnt == limit_q - TIMEOUT_W'(1));

    // Arrivals accumulate in ARMED, freeze in TIMEOUT, clear everywhere else
    // and on any exit from ARMED/TIMEOUT other than release.
    assign track = (state == SYNC_ARMED);
    assign clear = (state == SYNC_INIT) || (state == SYNC_IDLE) ||
                   (state == SYNC_RELEASE) || cfg_take ||
                   (abort_ok && ((state == SYNC_ARMED) || (state == SYNC_TIMEOUT)));

    assign sys__sync__state = state;

    mgr_sync_arrival_tracker #(
        .NUM_MGR (NUM_MGR)
    ) u_tracker (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .level         (mgr__sys__allSynchronized),
        .mask          (mask_q),
        .track         (track),
        .clear         (clear),
        .hit           (hit),
        .all_arrived   (all_arrived)
    );

    // Controller FSM with all outputs registered; pulses default low.
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state                      <= SYNC_INIT;
            init_cnt                   <= '0;
            mask_q                     <= '0;
            num_q                      <= '0;
            limit_q                    <= '0;
            tcnt                       <= '0;
            cfg__sync__ready           <= 1'b0;
            sys__mgr__thisSynchronized <= '0;
            sys__mgr__ready            <= '0;
            sys__mgr__complete         <= '0;
            sys__sync__barrierCount    <= '0;
            sys__sync__missing         <= '0;
            sys__sync__timeoutErr      <= 1'b0;
        end else begin
            sys__mgr__thisSynchronized <= '0;
            sys__mgr__complete         <= '0;
            case (state)
                SYNC_INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        state            <= SYNC_IDLE;
                        sys__mgr__ready  <= '1;
                        cfg__sync__ready <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + INIT_W'(1);
                    end
                end
                SYNC_IDLE, SYNC_TIMEOUT: begin
                    if (cfg_take) begin
                        state                   <= SYNC_ARMED;
                        mask_q                  <= cfg__sync__mask;
                        num_q                   <= cfg__sync__numBarriers;
                        limit_q                 <= cfg__sync__timeout;
                        tcnt                    <= '0;
                        cfg__sync__ready        <= 1'b0;
                        sys__sync__barrierCount <= '0;
                        sys__sync__timeoutErr   <= 1'b0;
                        sys__sync__missing      <= cfg__sync__mask;
                    end else if ((state == SYNC_TIMEOUT) && cfg__sync__abort) begin
                        state              <= SYNC_IDLE;
                        sys__sync__missing <= '0;
                    end
                end
                SYNC_ARMED: begin
                    if (all_arrived) begin
                        state                      <= SYNC_RELEASE;
                        sys__mgr__thisSynchronized <= mask_q;
                        sys__sync__barrierCount    <= count_inc;
                        sys__sync__missing         <= '0;
                        if (last_barrier) begin
                            sys__mgr__complete <= mask_q;
                        end
                    end else if (cfg__sync__abort) begin
                        state              <= SYNC_IDLE;
                        cfg__sync__ready   <= 1'b1;
                        sys__sync__missing <= '0;
                    end else if (expire) begin
                        state                 <= SYNC_TIMEOUT;
                        cfg__sync__ready      <= 1'b1;
                        sys__sync__timeoutErr <= 1'b1;
                        sys__sync__missing    <= mask_q & ~hit;
                    end else begin
                        tcnt               <= tcnt + TIMEOUT_W'(1);
                        sys__sync__missing <= mask_q & ~hit;
                    end
                end
                SYNC_RELEASE: begin
                    if ((num_q != '0) && (sys__sync__barrierCount == num_q)) begin
                        state            <= SYNC_IDLE;
                        cfg__sync__ready <= 1'b1;
                    end else begin
                        state              <= SYNC_ARMED;
                        tcnt               <= '0;
                        sys__sync__missing <= mask_q;
                    end
                end
                default: begin
                    state <= SYNC_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mgr_array_sync_cntl.sv
// Directed bench for mgr_array_sync_cntl with 8 managers: init delay, a
// single bounded barrier, unbounded rounds with a stalled round, timeout,
// timeout/completion and abort/completion races, and reset mid-release.
module tb_mgr_array_sync_cntl;
    import mgr_array_sync_cntl_pkg::*;

    localparam int N  = 8;
    localparam int CW = 16;
    localparam int TW = 20;
    localparam int IC = 16;

    logic          clk = 1'b0;
    logic          reset_poweron = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [N-1:0]  cfg_mask = '0;
    logic [CW-1:0] cfg_num = '0;
    logic [TW-1:0] cfg_to = '0;
    logic          cfg_abort = 1'b0;
    logic [N-1:0]  lvl = '0;
    logic [N-1:0]  this_sync;
    logic [N-1:0]  mgr_ready;
    logic [N-1:0]  complete;
    logic [CW-1:0] bar_cnt;
    logic [N-1:0]  missing;
    logic          terr;
    sync_state_e   st;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        logic          valid;
        logic [N-1:0]  mask;
        logic [CW-1:0] num;
        logic [TW-1:0] to;
        logic          abort;
        logic [N-1:0]  lvl;
        sync_state_e   e_st;
        logic [N-1:0]  e_ts;
        logic [N-1:0]  e_cp;
        logic [CW-1:0] e_cnt;
        logic [N-1:0]  e_miss;
        logic          e_terr;
        logic          e_crdy;
    } vec_t;

    vec_t tbl[9];

    mgr_array_sync_cntl #(
        .NUM_MGR     (N),
        .CNT_W       (CW),
        .TIMEOUT_W   (TW),
        .INIT_CYCLES (IC)
    ) dut (
        .clk                        (clk),
        .reset_poweron              (reset_poweron),
        .cfg__sync__valid           (cfg_valid),
        .cfg__sync__ready           (cfg_ready),
        .cfg__sync__mask            (cfg_mask),
        .cfg__sync__numBarriers     (cfg_num),
        .cfg__sync__timeout         (cfg_to),
        .cfg__sync__abort           (cfg_abort),
        .mgr__sys__allSynchronized  (lvl),
        .sys__mgr__thisSynchronized (this_sync),
        .sys__mgr__ready            (mgr_ready),
        .sys__mgr__complete         (complete),
        .sys__sync__barrierCount    (bar_cnt),
        .sys__sync__missing         (missing),
        .sys__sync__timeoutErr      (terr),
        .sys__sync__state           (st)
    );

    // Clock
    always #5 clk = ~clk;

    // Run-time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            checks_passed++;
        end
    endtask

    function automatic vec_t v(input logic valid, input logic [N-1:0] mask,
                               input logic [CW-1:0] num, input logic [TW-1:0] to,
                               input logic abort, input logic [N-1:0] l,
                               input sync_state_e e_st, input logic [N-1:0] e_ts,
                               input logic [N-1:0] e_cp, input logic [CW-1:0] e_cnt,
                               input logic [N-1:0] e_miss, input logic e_terr,
                               input logic e_crdy);
        vec_t r;
        r.valid = valid; r.mask = mask; r.num = num; r.to = to; r.abort = abort;
        r.lvl = l; r.e_st = e_st; r.e_ts = e_ts; r.e_cp = e_cp; r.e_cnt = e_cnt;
        r.e_miss = e_miss; r.e_terr = e_terr; r.e_crdy = e_crdy;
        return r;
    endfunction

    // Drive one vector at the falling edge, clock it, check at the next falling edge.
    task automatic apply(input vec_t t, input string tag);
        cfg_valid = t.valid;
        cfg_mask  = t.mask;
        cfg_num   = t.num;
        cfg_to    = t.to;
        cfg_abort = t.abort;
        lvl       = t.lvl;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " state"},    32'(st),        32'(t.e_st));
        chk({tag, " thisSync"}, 32'(this_sync), 32'(t.e_ts));
        chk({tag, " complete"}, 32'(complete),  32'(t.e_cp));
        chk({tag, " count"},    32'(bar_cnt),   32'(t.e_cnt));
        chk({tag, " missing"},  32'(missing),   32'(t.e_miss));
        chk({tag, " timeoutErr"}, 32'(terr),    32'(t.e_terr));
        chk({tag, " cfgReady"}, 32'(cfg_ready), 32'(t.e_crdy));
    endtask

    // Assert reset, check outputs clear at once, then walk the init delay.
    task automatic do_init(input string tag);
        reset_poweron = 1'b0;
        #1;
        chk({tag, " rst thisSync"}, 32'(this_sync), 32'h0);
        chk({tag, " rst ready"},    32'(mgr_ready), 32'h0);
        chk({tag, " rst complete"}, 32'(complete),  32'h0);
        chk({tag, " rst count"},    32'(bar_cnt),   32'h0);
        chk({tag, " rst missing"},  32'(missing),   32'h0);
        chk({tag, " rst timeoutErr"}, 32'(terr),    32'h0);
        chk({tag, " rst cfgReady"}, 32'(cfg_ready), 32'h0);
        cfg_valid = 1'b0; cfg_abort = 1'b0; lvl = '0;
        @(negedge clk);
        @(negedge clk);
        reset_poweron = 1'b1;
        for (int i = 1; i <= IC; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s init%0d ready", tag, i), 32'(mgr_ready), (i == IC) ? 32'hFF : 32'h0);
            chk($sformatf("%s init%0d cfgReady", tag, i), 32'(cfg_ready), (i == IC) ? 32'h1 : 32'h0);
        end
        chk({tag, " init state"}, 32'(st), 32'(SYNC_IDLE));
    endtask

    initial begin
        // Single bounded barrier with staggered arrivals and an unmasked toggler,
        // then a zero-mask config that must be dropped.
        tbl[0] = v(1, 8'h0F, 1, 0, 0, 8'h00, SYNC_ARMED,   8'h00, 8'h00, 0, 8'h0F, 0, 0);
        tbl[1] = v(0, 8'h0F, 1, 0, 0, 8'h01, SYNC_ARMED,   8'h00, 8'h00, 0, 8'h0E, 0, 0);
        tbl[2] = v(0, 8'h0F, 1, 0, 0, 8'h03, SYNC_ARMED,   8'h00, 8'h00, 0, 8'h0C, 0, 0);
        tbl[3] = v(0, 8'h0F, 1, 0, 0, 8'h23, SYNC_ARMED,   8'h00, 8'h00, 0, 8'h0C, 0, 0);
        tbl[4] = v(0, 8'h0F, 1, 0, 0, 8'h07, SYNC_ARMED,   8'h00, 8'h00, 0, 8'h08, 0, 0);
        tbl[5] = v(0, 8'h0F, 1, 0, 0, 8'h27, SYNC_ARMED,   8'h00, 8'h00, 0, 8'h08, 0, 0);
        tbl[6] = v(0, 8'h0F, 1, 0, 0, 8'h0F, SYNC_RELEASE, 8'h0F, 8'h0F, 1, 8'h00, 0, 0);
        tbl[7] = v(0, 8'h0F, 1, 0, 0, 8'h0F, SYNC_IDLE,    8'h00, 8'h00, 1, 8'h00, 0, 1);
        tbl[8] = v(1, 8'h00, 3, 5, 0, 8'h00, SYNC_IDLE,    8'h00, 8'h00, 1, 8'h00, 0, 1);

        #2;
        do_init("por");

        for (int i = 0; i < 9; i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        // Unbounded mode: five rounds, then a round stalled by a held level.
        apply(v(1, 8'hFF, 0, 0, 0, 8'h00, SYNC_ARMED, 8'h00, 8'h00, 0, 8'hFF, 0, 0), "unb cfg");
        for (int r = 0; r < 5; r++) begin
            logic [N-1:0] hold;
            hold = (r == 4) ? 8'hFF : 8'h00;
            apply(v(0, 8'hFF, 0, 0, 0, 8'hFF, SYNC_RELEASE, 8'hFF, 8'h00, CW'(r + 1), 8'h00, 0, 0),
                  $sformatf("unb rel%0d", r));
            apply(v(r == 0, 8'h01, 1, 0, 0, hold, SYNC_ARMED, 8'h00, 8'h00, CW'(r + 1), 8'hFF, 0, 0),
                  $sformatf("unb gapA%0d", r));
            apply(v(0, 8'hFF, 0, 0, 0, hold, SYNC_ARMED, 8'h00, 8'h00, CW'(r + 1), 8'hFF, 0, 0),
                  $sformatf("unb gapB%0d", r));
        end
        apply(v(0, 8'hFF, 0, 0, 0, 8'h01, SYNC_ARMED, 8'h00, 8'h00, 5, 8'hFF, 0, 0), "stall drop");
        apply(v(0, 8'hFF, 0, 0, 0, 8'hFF, SYNC_ARMED, 8'h00, 8'h00, 5, 8'h01, 0, 0), "stall held");
        apply(v(0, 8'hFF, 0, 0, 1, 8'hFF, SYNC_IDLE,  8'h00, 8'h00, 5, 8'h00, 0, 1), "stall abort");

        // Timeout of 10 with manager 6 absent.
        apply(v(1, 8'hFF, 0, 10, 0, 8'h00, SYNC_ARMED, 8'h00, 8'h00, 0, 8'hFF, 0, 0), "to cfg");
        for (int i = 1; i <= 9; i++) begin
            apply(v(0, 8'hFF, 0, 10, 0, 8'hBF, SYNC_ARMED, 8'h00, 8'h00, 0, 8'h40, 0, 0),
                  $sformatf("to wait%0d", i));
        end
        apply(v(0, 8'hFF, 0, 10, 0, 8'hBF, SYNC_TIMEOUT, 8'h00, 8'h00, 0, 8'h40, 1, 1), "to expire");
        apply(v(0, 8'hFF, 0, 10, 0, 8'hFF, SYNC_TIMEOUT, 8'h00, 8'h00, 0, 8'h40, 1, 1), "to frozen");
        apply(v(0, 8'hFF, 0, 10, 1, 8'hFF, SYNC_IDLE,    8'h00, 8'h00, 0, 8'h00, 1, 1), "to abort");

        // Last arrival on the timeout-expiry edge: release and completion win.
        apply(v(1, 8'h03, 1, 4, 0, 8'h00, SYNC_ARMED, 8'h00, 8'h00, 0, 8'h03, 0, 0), "race cfg");
        for (int i = 1; i <= 3; i++) begin
            apply(v(0, 8'h03, 1, 4, 0, 8'h00, SYNC_ARMED, 8'h00, 8'h00, 0, 8'h03, 0, 0),
                  $sformatf("race wait%0d", i));
        end
        apply(v(0, 8'h03, 1, 4, 0, 8'h03, SYNC_RELEASE, 8'h03, 8'h03, 1, 8'h00, 0, 0), "race rel");
        apply(v(0, 8'h03, 1, 4, 0, 8'h03, SYNC_IDLE,    8'h00, 8'h00, 1, 8'h00, 0, 1), "race idle");

        // Abort coinciding with a release (intermediate and final).
        apply(v(1, 8'h03, 2, 0, 0, 8'h00, SYNC_ARMED,   8'h00, 8'h00, 0, 8'h03, 0, 0), "ab cfg");
        apply(v(0, 8'h03, 2, 0, 1, 8'h03, SYNC_RELEASE, 8'h03, 8'h00, 1, 8'h00, 0, 0), "ab rel1");
        apply(v(0, 8'h03, 2, 0, 0, 8'h03, SYNC_ARMED,   8'h00, 8'h00, 1, 8'h03, 0, 0), "ab rearm");
        apply(v(0, 8'h03, 2, 0, 0, 8'h00, SYNC_ARMED,   8'h00, 8'h00, 1, 8'h03, 0, 0), "ab drop");
        apply(v(0, 8'h03, 2, 0, 1, 8'h03, SYNC_RELEASE, 8'h03, 8'h03, 2, 8'h00, 0, 0), "ab rel2");
        apply(v(0, 8'h03, 2, 0, 0, 8'h03, SYNC_IDLE,    8'h00, 8'h00, 2, 8'h00, 0, 1), "ab idle");

        // Reset asserted in the middle of a release cycle.
        apply(v(1, 8'h01, 0, 0, 0, 8'h00, SYNC_ARMED,   8'h00, 8'h00, 0, 8'h01, 0, 0), "mid cfg");
        apply(v(0, 8'h01, 0, 0, 0, 8'h01, SYNC_RELEASE, 8'h01, 8'h00, 1, 8'h00, 0, 0), "mid rel");
        do_init("mid");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
